// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that lets N requesters write one shared WIDTH-bit register
// over valid/ready, then holds off new requests for HOLD quiet cycles after each write.
module shared_reg_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned HOLD  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req_valid,
    input  logic [N*WIDTH-1:0]     req_data,
    output logic [N-1:0]           req_ready,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid,
    output logic [$clog2(N)-1:0]   grant_id,
    output logic                   busy
);

    localparam int unsigned PTR_W = $clog2(N);
    localparam int unsigned CNT_W = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [PTR_W-1:0] ptr_q,   ptr_d;
    logic [WIDTH-1:0] q_q,     q_d;
    logic             q_valid_q, q_valid_d;
    logic [PTR_W-1:0] grant_q, grant_d;
    logic             busy_q,  busy_d;

    logic             found;
    logic [PTR_W-1:0] win;
    logic [N-1:0]     rot_valid;
    logic [WIDTH-1:0] win_data;
    logic             accept;

    // Rotate the request vector so index 0 is the current priority holder.
    always_comb begin : arb_search
        rot_valid = N'({req_valid, req_valid} >> ptr_q);
        found     = 1'b0;
        win       = '0;
        for (int unsigned off = 0; off < N; off++) begin
            if (!found && rot_valid[off]) begin
                found = 1'b1;
                win   = PTR_W'((32'(ptr_q) + off) % N);
            end
        end
    end

    always_comb begin : data_mux
        win_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (win == PTR_W'(i)) begin
                win_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign accept    = !rst && (state_q == ST_IDLE) && found;
    assign req_ready = accept ? (N'(1) << win) : '0;

    // Next-state and registered-output logic.
    always_comb begin : fsm_next
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        q_d       = q_q;
        q_valid_d = 1'b0;
        grant_d   = grant_q;
        busy_d    = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    q_d       = win_data;
                    grant_d   = win;
                    q_valid_d = 1'b1;
                    ptr_d     = (32'(win) == N - 1) ? '0 : win + PTR_W'(1);
                    if (HOLD != 0) begin
                        state_d = ST_HOLD;
                        cnt_d   = CNT_W'(HOLD - 1);
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin : fsm_regs
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
        end
    end

    assign q        = q_q;
    assign q_valid  = q_valid_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: a HOLD=2 and a HOLD=0 instance share stimulus and
// are compared every cycle against a queue-free per-rule reference model.
module tb_shared_reg_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data  = '0;

    logic [N-1:0]   rdy  [2];
    logic [W-1:0]   qo   [2];
    logic           qv   [2];
    logic [1:0]     gid  [2];
    logic           bsy  [2];

    int checks = 0;
    int errors = 0;

    // Reference model state: one set per instance (0: HOLD=2, 1: HOLD=0).
    int           hold_of [2] = '{2, 0};
    int           m_ptr   [2];
    int           m_quiet [2];
    int           m_gid   [2];
    logic [W-1:0] m_q     [2];
    logic         m_qv    [2];

    always #5 clk = ~clk;

    shared_reg_arbiter #(.N(N), .WIDTH(W), .HOLD(2)) dut_h2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy[0]), .q(qo[0]), .q_valid(qv[0]), .grant_id(gid[0]), .busy(bsy[0])
    );

    shared_reg_arbiter #(.N(N), .WIDTH(W), .HOLD(0)) dut_h0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy[1]), .q(qo[1]), .q_valid(qv[1]), .grant_id(gid[1]), .busy(bsy[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Winner index for instance k this cycle, or -1 when nothing may be accepted.
    function automatic int m_winner(int k);
        if (rst || m_quiet[k] > 0) return -1;
        for (int off = 0; off < int'(N); off++) begin
            int i = (m_ptr[k] + off) % int'(N);
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready(int k);
        logic [N-1:0] r = '0;
        int w = m_winner(k);
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic m_update(int k);
        int w = m_winner(k);
        if (rst) begin
            m_ptr[k] = 0; m_quiet[k] = 0; m_gid[k] = 0; m_q[k] = '0; m_qv[k] = 1'b0;
        end else if (w >= 0) begin
            m_q[k]     = req_data[w*W +: W];
            m_gid[k]   = w;
            m_ptr[k]   = (w + 1) % int'(N);
            m_qv[k]    = 1'b1;
            m_quiet[k] = hold_of[k];
        end else begin
            m_qv[k] = 1'b0;
            if (m_quiet[k] > 0) m_quiet[k]--;
        end
    endtask

    // One clock: compare both instances at the falling edge, advance the model at the rising edge.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ready%0d", k), 32'(rdy[k]), 32'(m_ready(k)));
            chk($sformatf("q%0d", k),     32'(qo[k]),  32'(m_q[k]));
            chk($sformatf("qv%0d", k),    32'(qv[k]),  32'(m_qv[k]));
            chk($sformatf("gid%0d", k),   32'(gid[k]), 32'(m_gid[k]));
            chk($sformatf("busy%0d", k),  32'(bsy[k]), 32'(m_quiet[k] > 0));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) m_update(k);
        #1;
    endtask

    task automatic do_reset(int cycles);
        rst = 1'b1;
        for (int c = 0; c < cycles; c++) step();
        rst = 1'b0;
    endtask

    logic [1:0] rot_gid [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    int         rot_n;

    initial begin
        @(posedge clk);
        for (int k = 0; k < 2; k++) m_update(k);
        #1;
        do_reset(2);

        // Single request after reset.
        req_valid = 4'b0100;
        req_data  = 32'h00A5_0000;
        #1 chk("p1_ready", 32'(rdy[0]), 32'h4);
        step();
        req_valid = '0;
        chk("p1_q",    32'(qo[0]),  32'hA5);
        chk("p1_qv",   32'(qv[0]),  32'h1);
        chk("p1_gid",  32'(gid[0]), 32'h2);
        chk("p1_busy", 32'(bsy[0]), 32'h1);
        step();
        chk("p1_busy2", 32'(bsy[0]), 32'h1);
        step();
        chk("p1_idle", 32'(bsy[0]), 32'h0);

        // Wrap: ptr is 3, requesters 3 and 0 valid.
        req_valid = 4'b1001;
        req_data  = 32'h3300_0030;
        step();
        chk("wrap_first", 32'(gid[0]), 32'h3);
        for (int c = 0; c < 3; c++) step();
        chk("wrap_second", 32'(gid[0]), 32'h0);
        chk("wrap_q",      32'(qo[0]),  32'h30);
        req_valid = '0;
        for (int c = 0; c < 3; c++) step();

        // Full rotation with all four valid.
        do_reset(1);
        req_valid = 4'b1111;
        req_data  = 32'h1312_1110;
        rot_n = 0;
        for (int c = 0; c < 14; c++) begin
            step();
            if (qv[0] && rot_n < 5) begin
                chk("rot_gid", 32'(gid[0]), 32'(rot_gid[rot_n]));
                chk("rot_q",   32'(qo[0]),  32'h10 + 32'(rot_gid[rot_n]));
                rot_n++;
            end
        end
        chk("rot_count", 32'(rot_n), 32'd5);
        req_valid = '0;
        for (int c = 0; c < 3; c++) step();

        // Back-to-back accepts with HOLD=0.
        do_reset(1);
        req_valid = 4'b0011;
        req_data  = 32'h0000_0201;
        step();
        chk("b2b_q0",  32'(qo[1]),  32'h01);
        chk("b2b_qv0", 32'(qv[1]),  32'h1);
        step();
        chk("b2b_q1",   32'(qo[1]),  32'h02);
        chk("b2b_qv1",  32'(qv[1]),  32'h1);
        chk("b2b_busy", 32'(bsy[1]), 32'h0);
        req_valid = '0;
        for (int c = 0; c < 3; c++) step();

        // Request blocked during the hold window.
        do_reset(1);
        req_valid = 4'b0001;
        req_data  = 32'h0000_4140;
        step();
        req_valid = 4'b0010;
        #1 chk("blk_r0", 32'(rdy[0]), 32'h0);
        step();
        chk("blk_r1", 32'(rdy[0]), 32'h0);
        step();
        chk("blk_r2", 32'(rdy[0]), 32'h2);
        step();
        req_valid = '0;
        chk("blk_q",   32'(qo[0]),  32'h41);
        chk("blk_gid", 32'(gid[0]), 32'h1);
        for (int c = 0; c < 3; c++) step();

        // Reset during the hold window.
        req_valid = 4'b0001;
        req_data  = 32'h0000_005A;
        step();
        chk("rh_q",    32'(qo[0]),  32'h5A);
        chk("rh_busy", 32'(bsy[0]), 32'h1);
        rst = 1'b1;
        #1 chk("rh_rdy_rst", 32'(rdy[0]), 32'h0);
        step();
        rst = 1'b0;
        chk("rh_q0",    32'(qo[0]),  32'h0);
        chk("rh_busy0", 32'(bsy[0]), 32'h0);
        chk("rh_qv0",   32'(qv[0]),  32'h0);
        #1 chk("rh_rdy", 32'(rdy[0]), 32'h1);
        step();
        chk("rh_acc", 32'(qo[0]), 32'h5A);
        req_valid = '0;
        step();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 49) == 0);
            req_valid = N'($urandom);
            req_data  = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit register among N requesters through a valid/ready handshake.
- It sequences exclusive writes into the register, then enforces a programmable quiet (hold) window after each write.
- It sits in front of any module-level register that several procedural blocks or upstream units must update without write conflicts.

Parameters:
- N, 4, number of requesters (2..16).
- WIDTH, 8, data width of each requester and of the shared register.
- HOLD, 2, quiet cycles after each accepted write (0..15); during this window no request is accepted.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N  bit i high means requester i offers data.
- req_data  input  N*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- req_ready  output  N  one-hot or zero; bit i high means requester i is accepted this cycle (combinational).
- q  output  WIDTH  shared register contents.
- q_valid  output  1  one-cycle pulse the cycle after q is updated.
- grant_id  output  $clog2(N)  index of the last accepted requester.
- busy  output  1  high while in the HOLD state.

Behaviour:
- Reset (rst=1 at a clk edge):
  - q=0, q_valid=0, grant_id=0, busy=0.
  - Round-robin pointer ptr=0, state=IDLE, hold counter=0.
  - req_ready is all-zero while rst=1.
- States: IDLE and HOLD.
- IDLE:
  - If any req_valid bit is set, the winner w is the first set index scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - req_ready[w]=1 combinationally in the same cycle; all other bits are 0.
  - At the clk edge:
    - q <= req_data[w], grant_id <= w, ptr <= (w+1) mod N, q_valid <= 1.
    - If HOLD>0: state <= HOLD, cnt <= HOLD-1, busy <= 1.
    - If HOLD=0: stay in IDLE; back-to-back accepts occur every cycle.
  - If no valid: req_ready=0 and q_valid <= 0; q, ptr and grant_id are held.
- HOLD:
  - req_ready=0 regardless of req_valid; q_valid <= 0.
  - If cnt=0: state <= IDLE, busy <= 0. Otherwise cnt <= cnt-1.
  - Exactly HOLD cycles are spent in HOLD, so the accept-to-accept spacing is HOLD+1 cycles.
- Handshake:
  - A transfer occurs only when req_valid[i] and req_ready[i] are both high in the same cycle.
  - Requesters must hold valid and data until accepted.
  - Dropping valid before acceptance withdraws the request; nothing is latched.
- Latency: q and q_valid reflect the accepted data on the first edge after the accept cycle.
- Wrap-around:
  - The ptr increment wraps modulo N.
  - When w=N-1, ptr becomes 0.
- Fairness: with all N requesters continuously valid, grants rotate 0,1,...,N-1,0,... and no requester waits more than N-1 grants.
- Single requester: when only requester k is valid, it wins regardless of ptr.
- Reset mid-HOLD:
  - HOLD is aborted and state returns to IDLE.
  - q is cleared to 0.
  - A request pending during reset is not accepted until the first cycle with rst=0.
- Simultaneous reset and accept: reset wins; nothing is latched and ptr=0.
- Width rules:
  - q is exactly WIDTH bits; no extension or truncation.
  - grant_id width is $clog2(N) (minimum 1).

Test Plan:
- Reset then single request: rst 2 cycles, then req_valid=4'b0100, data2=8'hA5.
  - Required: req_ready=4'b0100 in the same cycle; next cycle q=8'hA5, q_valid=1, grant_id=2.
  - Then busy=1 for 2 cycles; ptr=3.
- Round-robin rotation: all four valid continuously, data_i=8'h10+i, HOLD=2.
  - Required: grants in order 0,1,2,3,0 with accepts exactly 3 cycles apart.
  - q sequence 10,11,12,13,10.
- Wrap/priority: ptr=3 (after granting requester 2), req_valid=4'b1001.
  - Required: requester 3 is granted first, ptr=0, then requester 0 is granted next.
- HOLD=0 back-to-back: requesters 0 and 1 valid with data 8'h01 and 8'h02.
  - Required: accepts on consecutive cycles; q=01 then 02; q_valid high 2 consecutive cycles; busy stays 0.
- Request blocked in HOLD: requester 1 raises valid during the HOLD window of a requester-0 grant.
  - Required: req_ready stays 0 until busy falls.
  - Requester 1 is accepted in the first IDLE cycle and q updates one cycle later.
- Reset mid-HOLD: assert rst for 1 cycle while busy=1 and q=8'h5A.
  - Required: next cycle q=0, busy=0, q_valid=0.
  - A pending req_valid=4'b0001 is accepted on the cycle after rst falls.
